dot_feeder: RTL and testbench

DOT_FEEDER -- requirements
Module: dot_feeder

---
 rtl/dot_pkg.sv | 15 +
 rtl/vec_buf.sv | 32 +++
 rtl/dot_feeder.sv | 170 +++++++++++++++++
 tb/tb_dot_feeder.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/dot_pkg.sv
// Shared defaults and FSM state encoding for the dot-product feeder.
package dot_pkg;
    localparam int VEC_LEN_DEF = 5;
    localparam int DATA_W_DEF  = 8;
    localparam int RES_W_DEF   = 16;
    localparam int TIMEOUT_DEF = 64;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        WAIT_BUSY = 3'd2,
        STREAM    = 3'd3,
        DRAIN     = 3'd4
    } state_t;
endpackage

// File: rtl/vec_buf.sv
// Operand store: VEC_LEN entries of {A,B}, one synchronous write port and
// one combinational read port. Out-of-range addresses neither write nor read.
module vec_buf
    import dot_pkg::*;
#(
    parameter int VEC_LEN = VEC_LEN_DEF,
    parameter int DATA_W  = DATA_W_DEF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                i_we,
    input  logic [2:0]          i_waddr,
    input  logic [2*DATA_W-1:0] i_wdata,
    input  logic [2:0]          i_raddr,
    output logic [2*DATA_W-1:0] o_rdata
);
    logic [2*DATA_W-1:0] r_mem [VEC_LEN];
    logic                w_wr_ok;
    logic                w_rd_ok;

    assign w_wr_ok = i_we && (int'(i_waddr) < VEC_LEN);
    assign w_rd_ok = int'(i_raddr) < VEC_LEN;
    assign o_rdata = w_rd_ok ? r_mem[i_raddr] : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < VEC_LEN; i++) r_mem[i] <= '0;
        end else if (w_wr_ok) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end
endmodule

// File: rtl/dot_feeder.sv
// Streams the buffered A/B vectors into a dot-product engine and captures its
// result, aborting with an err pulse if the engine handshake stalls.
module dot_feeder
    import dot_pkg::*;
#(
    parameter int VEC_LEN = VEC_LEN_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int RES_W   = RES_W_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [2:0]        wr_addr,
    input  logic [DATA_W-1:0] wr_a,
    input  logic [DATA_W-1:0] wr_b,
    input  logic              go,
    output logic              ready,
    output logic              dp_start,
    output logic [DATA_W-1:0] dp_a,
    output logic [DATA_W-1:0] dp_b,
    output logic              dp_valid,
    input  logic              dp_busy,
    input  logic [RES_W-1:0]  dp_result,
    output logic [RES_W-1:0]  result,
    output logic              done,
    output logic              err
);
    // state     | meaning
    // IDLE      | ready; accepts buffer writes and go
    // START     | single-cycle dp_start pulse
    // WAIT_BUSY | waiting for engine to raise dp_busy
    // STREAM    | presenting elements 0..VEC_LEN-1 with dp_valid
    // DRAIN     | waiting for dp_busy to fall, then capture dp_result

    localparam int                CNT_W     = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0]  WAIT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [2:0]        IDX_LAST  = 3'(VEC_LEN - 1);

    state_t              r_state, w_next;
    logic [2:0]          r_idx, w_idx_next;
    logic [CNT_W-1:0]    r_wait, w_wait_next;

    logic                r_ready, r_dp_start, r_dp_valid, r_done, r_err;
    logic [DATA_W-1:0]   r_dp_a, r_dp_b;
    logic [RES_W-1:0]    r_result;

    logic                w_start_nx, w_valid_nx, w_done_nx, w_err_nx, w_ready_nx;
    logic [DATA_W-1:0]   w_a_nx, w_b_nx;
    logic [RES_W-1:0]    w_result_nx;

    logic                w_we;
    logic [2:0]          w_rd_idx;
    logic [2*DATA_W-1:0] w_rd_data;

    assign w_we     = wr_en && (r_state == IDLE);
    // Outputs are registered, so the read port looks one element ahead.
    assign w_rd_idx = (r_state == STREAM) ? (r_idx + 3'd1) : 3'd0;

    vec_buf #(
        .VEC_LEN (VEC_LEN),
        .DATA_W  (DATA_W)
    ) u_vec_buf (
        .clk     (clk),
        .reset   (reset),
        .i_we    (w_we),
        .i_waddr (wr_addr),
        .i_wdata ({wr_a, wr_b}),
        .i_raddr (w_rd_idx),
        .o_rdata (w_rd_data)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            r_idx      <= '0;
            r_wait     <= '0;
            r_ready    <= 1'b1;
            r_dp_start <= 1'b0;
            r_dp_valid <= 1'b0;
            r_dp_a     <= '0;
            r_dp_b     <= '0;
            r_result   <= '0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_idx      <= w_idx_next;
            r_wait     <= w_wait_next;
            r_ready    <= w_ready_nx;
            r_dp_start <= w_start_nx;
            r_dp_valid <= w_valid_nx;
            r_dp_a     <= w_a_nx;
            r_dp_b     <= w_b_nx;
            r_result   <= w_result_nx;
            r_done     <= w_done_nx;
            r_err      <= w_err_nx;
        end
    end

    always_comb begin
        w_next      = r_state;
        w_idx_next  = r_idx;
        w_wait_next = r_wait;
        w_valid_nx  = 1'b0;
        w_a_nx      = '0;
        w_b_nx      = '0;
        w_done_nx   = 1'b0;
        w_err_nx    = 1'b0;
        w_result_nx = r_result;

        case (r_state)
            IDLE: begin
                if (go) w_next = START;
            end
            START: begin
                w_next      = WAIT_BUSY;
                w_wait_next = '0;
            end
            WAIT_BUSY: begin
                if (dp_busy) begin
                    w_next           = STREAM;
                    w_idx_next       = '0;
                    w_valid_nx       = 1'b1;
                    {w_a_nx, w_b_nx} = w_rd_data;
                end else if (r_wait == WAIT_LAST) begin
                    w_next   = IDLE;
                    w_err_nx = 1'b1;
                end else begin
                    w_wait_next = r_wait + CNT_W'(1);
                end
            end
            STREAM: begin
                if (r_idx == IDX_LAST) begin
                    w_next      = DRAIN;
                    w_wait_next = '0;
                end else begin
                    w_idx_next       = r_idx + 3'd1;
                    w_valid_nx       = 1'b1;
                    {w_a_nx, w_b_nx} = w_rd_data;
                end
            end
            DRAIN: begin
                if (!dp_busy) begin
                    w_next      = IDLE;
                    w_result_nx = dp_result;
                    w_done_nx   = 1'b1;
                end else if (r_wait == WAIT_LAST) begin
                    w_next   = IDLE;
                    w_err_nx = 1'b1;
                end else begin
                    w_wait_next = r_wait + CNT_W'(1);
                end
            end
            default: w_next = IDLE;
        endcase

        w_start_nx = (w_next == START);
        w_ready_nx = (w_next == IDLE);
    end

    assign ready    = r_ready;
    assign dp_start = r_dp_start;
    assign dp_valid = r_dp_valid;
    assign dp_a     = r_dp_a;
    assign dp_b     = r_dp_b;
    assign result   = r_result;
    assign done     = r_done;
    assign err      = r_err;
endmodule

// File: tb/tb_dot_feeder.sv
// Bench for dot_feeder paired with a behavioural dot-product engine.
module tb_dot_feeder;
    localparam int VL = 5;
    localparam int DW = 8;
    localparam int RW = 16;
    localparam int TO = 64;

    logic          clk = 1'b0;
    logic          reset, wr_en, go, dp_busy;
    logic [2:0]    wr_addr;
    logic [DW-1:0] wr_a, wr_b, dp_a, dp_b;
    logic [RW-1:0] dp_result, result;
    logic          ready, dp_start, dp_valid, done, err;

    dot_feeder #(.VEC_LEN(VL), .DATA_W(DW), .RES_W(RW), .TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_a(wr_a), .wr_b(wr_b), .go(go), .ready(ready), .dp_start(dp_start),
        .dp_a(dp_a), .dp_b(dp_b), .dp_valid(dp_valid), .dp_busy(dp_busy),
        .dp_result(dp_result), .result(result), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    // Engine: raises busy eng_lat+1 cycles after dp_start, accumulates the
    // streamed products, drops busy with the sum one cycle after the last.
    logic          eng_stall, eng_hang;
    int            eng_lat, e_pend, e_cnt;
    logic [RW-1:0] e_acc;
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            dp_busy <= 1'b0; dp_result <= '0; e_pend <= -1; e_cnt <= 0; e_acc <= '0;
        end else begin
            if (dp_start && !eng_stall) e_pend <= eng_lat;
            else if (e_pend == 0) begin
                dp_busy <= 1'b1; e_pend <= -1; e_cnt <= 0; e_acc <= '0;
            end else if (e_pend > 0) e_pend <= e_pend - 1;
            if (dp_busy && dp_valid) begin
                e_acc <= e_acc + 16'(dp_a) * 16'(dp_b);
                e_cnt <= e_cnt + 1;
            end
            if (dp_busy && e_cnt == VL && !eng_hang) begin
                dp_busy <= 1'b0; dp_result <= e_acc; e_cnt <= 0;
            end
        end
    end

    int n_cmp = 0, n_bad = 0;
    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Reference model of the operand store and the expected dot product.
    logic [DW-1:0] m_a [VL];
    logic [DW-1:0] m_b [VL];
    logic [RW-1:0] last_res;
    function automatic logic [RW-1:0] ref_dot();
        int s = 0;
        for (int i = 0; i < VL; i++) s += int'(m_a[i]) * int'(m_b[i]);
        return 16'(s % 65536);
    endfunction

    // Monitor samples 1ns after each rising edge.
    int mon_valid, mon_done, mon_err, mon_start, mon_proto;
    logic [DW-1:0] sa_q[$], sb_q[$];
    always @(posedge clk) begin
        #1;
        if (!reset) begin
            if (dp_valid) begin sa_q.push_back(dp_a); sb_q.push_back(dp_b); mon_valid++; end
            else if (dp_a != 0 || dp_b != 0) mon_proto++;
            if (done) mon_done++;
            if (err) mon_err++;
            if (done && err) mon_proto++;
            if (dp_start) mon_start++;
            if (ready && (dp_valid || dp_start)) mon_proto++;
        end
    end

    task automatic clear_mon();
        mon_valid = 0; mon_done = 0; mon_err = 0; mon_start = 0; mon_proto = 0;
        sa_q.delete(); sb_q.delete();
    endtask

    task automatic wr(input logic [2:0] ad, input logic [DW-1:0] a, input logic [DW-1:0] b);
        wr_en = 1'b1; wr_addr = ad; wr_a = a; wr_b = b;
        @(negedge clk);
        wr_en = 1'b0;
        if (int'(ad) < VL) begin m_a[ad] = a; m_b[ad] = b; end
    endtask

    // Called at a negedge with the block idle; returns at the negedge where
    // done or err is first visible.
    task automatic run(input string nm, input logic [RW-1:0] exp, input bit exp_err,
                       input int exp_cyc, input bit inj);
        int  cyc, inj_st, bad;
        bit  fin;
        clear_mon();
        go = 1'b1;
        @(negedge clk);
        go = 1'b0; wr_en = 1'b0;
        check({nm, ".start"}, 32'(dp_start), 1);
        check({nm, ".ready_low"}, 32'(ready), 0);
        cyc = 0; fin = 0; inj_st = 0;
        while (!fin && cyc < 400) begin
            @(negedge clk);
            cyc++;
            if (inj_st == 1) begin wr_en = 1'b0; go = 1'b0; inj_st = 2; end
            else if (inj && inj_st == 0 && dp_valid) begin
                wr_en = 1'b1; wr_addr = 3'd0; wr_a = 8'd9; wr_b = 8'd9; go = 1'b1; inj_st = 1;
            end
            if (done || err) fin = 1;
        end
        check({nm, ".finished"}, 32'(fin), 1);
        if (exp_err) begin
            check({nm, ".err"}, 32'(err), 1);
            check({nm, ".no_done"}, 32'(mon_done), 0);
            if (exp_cyc > 0) check({nm, ".timeout_cycles"}, 32'(cyc), 32'(exp_cyc));
        end else begin
            check({nm, ".done"}, 32'(mon_done), 1);
            check({nm, ".valid_cycles"}, 32'(mon_valid), VL);
            check({nm, ".start_pulses"}, 32'(mon_start), 1);
            bad = 0;
            if (sa_q.size() != VL) bad++;
            else for (int i = 0; i < VL; i++)
                if (sa_q[i] !== m_a[i] || sb_q[i] !== m_b[i]) bad++;
            check({nm, ".stream"}, 32'(bad), 0);
            last_res = exp;
        end
        check({nm, ".result"}, 32'(result), 32'(exp));
        check({nm, ".ready_back"}, 32'(ready), 1);
        check({nm, ".protocol"}, 32'(mon_proto), 0);
    endtask

    typedef struct {
        logic [VL-1:0][DW-1:0] a;
        logic [VL-1:0][DW-1:0] b;
        logic [RW-1:0]         exp;
    } vec_t;
    vec_t tbl [5];

    initial begin
        int k, cyc;
        tbl[0].a = {8'd5, 8'd4, 8'd3, 8'd2, 8'd1};       tbl[0].b = {5{8'd1}};   tbl[0].exp = 16'd15;
        tbl[1].a = {5{8'd255}};                           tbl[1].b = {5{8'd255}}; tbl[1].exp = 16'd62981;
        tbl[2].a = {8'd50, 8'd40, 8'd30, 8'd20, 8'd10};  tbl[2].b = {5{8'd2}};   tbl[2].exp = 16'd300;
        tbl[3].a = {8'd255, 8'd0, 8'd255, 8'd0, 8'd255}; tbl[3].b = {5{8'd255}}; tbl[3].exp = 16'd64003;
        tbl[4].a = {8'd200, 8'd0, 8'd0, 8'd0, 8'd0};     tbl[4].b = {8'd3, 8'd0, 8'd0, 8'd0, 8'd0}; tbl[4].exp = 16'd600;

        reset = 1'b1; wr_en = 1'b0; go = 1'b0; wr_addr = '0; wr_a = '0; wr_b = '0;
        eng_stall = 1'b0; eng_hang = 1'b0; eng_lat = 0; last_res = '0;
        for (int i = 0; i < VL; i++) begin m_a[i] = '0; m_b[i] = '0; end
        clear_mon();
        repeat (2) @(negedge clk);
        check("rst.ready", 32'(ready), 1);
        check("rst.outs", 32'({dp_start, dp_valid, done, err}), 0);
        check("rst.data", 32'({dp_a, dp_b}), 0);
        check("rst.result", 32'(result), 0);
        reset = 1'b0;
        @(negedge clk);

        for (int t = 0; t < 5; t++) begin
            for (int i = 0; i < VL; i++) wr(3'(i), tbl[t].a[i], tbl[t].b[i]);
            run($sformatf("tbl%0d", t), tbl[t].exp, 0, -1, 0);
            if (t == 0) begin @(negedge clk); check("done_width", 32'(done), 0); end
        end

        // Write and go in the same cycle: the run sees the new element.
        wr_en = 1'b1; wr_addr = 3'd4; wr_a = 8'd10; wr_b = 8'd10;
        m_a[4] = 8'd10; m_b[4] = 8'd10;
        run("wr_go", ref_dot(), 0, -1, 0);

        // go and a write to element 0 during STREAM are both ignored.
        run("stream_ign", ref_dot(), 0, -1, 1);
        run("after_ign", ref_dot(), 0, -1, 0);

        wr(3'd6, 8'd77, 8'd77);
        wr(3'd5, 8'd66, 8'd66);
        wr(3'd7, 8'd55, 8'd55);
        run("addr_oob", ref_dot(), 0, -1, 0);

        // Back-to-back: second go issued in the cycle done is visible.
        wr(3'd1, 8'd3, 8'd4);
        run("b2b1", ref_dot(), 0, -1, 0);
        run("b2b2", ref_dot(), 0, -1, 0);

        // Engine never goes busy: START cycle plus TIMEOUT cycles in WAIT_BUSY.
        @(negedge clk);
        eng_stall = 1'b1;
        run("to_wait", last_res, 1, TO + 1, 0);
        eng_stall = 1'b0;

        eng_hang = 1'b1;
        @(negedge clk);
        run("to_drain", last_res, 1, -1, 0);
        eng_hang = 1'b0;
        repeat (3) @(negedge clk);

        // Reset during the 3rd STREAM cycle.
        clear_mon();
        go = 1'b1;
        @(negedge clk);
        go = 1'b0; k = 0; cyc = 0;
        while (k < 3 && cyc < 100) begin
            @(negedge clk); cyc++;
            if (dp_valid) k++;
        end
        check("rst_mid.reached", 32'(k), 3);
        reset = 1'b1;
        #1;
        check("rst_mid.valid", 32'({dp_valid, dp_start}), 0);
        check("rst_mid.no_done_err", 32'({done, err}), 0);
        for (int i = 0; i < VL; i++) begin m_a[i] = '0; m_b[i] = '0; end
        last_res = '0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rst_mid.ready", 32'(ready), 1);
        check("rst_mid.result", 32'(result), 0);
        check("rst_mid.quiet", 32'(mon_done + mon_err), 0);
        run("post_rst", 16'd0, 0, -1, 0);

        for (int r = 0; r < 8; r++) begin
            for (int w = 0; w < 6; w++)
                wr(3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom));
            eng_lat = $urandom_range(0, 3);
            run($sformatf("rand%0d", r), ref_dot(), 0, -1, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
